// File: rtl/cache_bus_responder_pkg.sv
// Shared definitions for the cache bus responder slice.
// Contents:
//   busRespState_t - responder FSM states, also exported on the StateDbg port
//   BUS_RW_*       - CacheBusRW encodings ([1] line fetch, [0] line writeback)
package cache_bus_responder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_READ  = 3'd2,
        ST_WRITE = 3'd3,
        ST_ACK   = 3'd4
    } busRespState_t;

    localparam logic [1:0] BUS_RW_NONE    = 2'b00;
    localparam logic [1:0] BUS_RW_WRITE   = 2'b01;
    localparam logic [1:0] BUS_RW_READ    = 2'b10;
    localparam logic [1:0] BUS_RW_ILLEGAL = 2'b11;

endpackage

// File: rtl/cache_bus_responder_if.sv
// Cache <-> bus responder signal bundle.
// Handshake: the requester (master) raises CacheBusRW with a line-aligned
// CacheBusAdr and holds both until it sees CacheBusAck, which the responder
// (slave) drives high for exactly one cycle; the requester drops CacheBusRW
// in that ack cycle. During writeback beats SelBusBeat is high and the
// requester must drive WriteBeatData as a combinational function of
// BeatCount. Dropping CacheBusRW to 00 before the ack aborts the operation.
// Modports:
//   master - requester side: drives CacheBusRW, CacheBusAdr, WriteBeatData
//   slave  - responder side: drives FetchBuffer, BeatCount, SelBusBeat,
//            CacheBusAck, ProtocolErr
interface cache_bus_responder_if #(
    parameter int PA_BITS = 32,
    parameter int LINELEN = 256,
    parameter int BEATLEN = 64
);
    localparam int BEATSPERLINE = LINELEN / BEATLEN;
    localparam int LOGBWPL      = $clog2(BEATSPERLINE);

    logic [1:0]         CacheBusRW;
    logic [PA_BITS-1:0] CacheBusAdr;
    logic [BEATLEN-1:0] WriteBeatData;
    logic [LINELEN-1:0] FetchBuffer;
    logic [LOGBWPL-1:0] BeatCount;
    logic               SelBusBeat;
    logic               CacheBusAck;
    logic               ProtocolErr;

    modport master (
        output CacheBusRW, CacheBusAdr, WriteBeatData,
        input  FetchBuffer, BeatCount, SelBusBeat, CacheBusAck, ProtocolErr
    );

    modport slave (
        input  CacheBusRW, CacheBusAdr, WriteBeatData,
        output FetchBuffer, BeatCount, SelBusBeat, CacheBusAck, ProtocolErr
    );
endinterface

// File: rtl/cache_bus_responder_busresp_ram.sv
// busresp_ram: beat-addressed backing store for the bus responder.
// Single port, synchronous write, combinational read. Contents are not reset.
// Ports:
//   clk   - clock
//   we    - write enable for the beat at addr
//   addr  - beat address {line, beat}
//   wdata - beat to write
//   rdata - beat currently at addr
module busresp_ram #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];
endmodule

// File: rtl/cache_bus_responder.sv
// cache_bus_responder: bus-side model of a memory that serves cache line
// fetches and writebacks beat by beat after a fixed access latency.
// Ports:
//   clk      - clock, all state on rising edge
//   reset_n  - asynchronous active-low reset
//   bus      - cache bus bundle (slave side)
//   StateDbg - current FSM state
// Timing: the accept edge leaves IDLE; LATENCY WAIT cycles follow, then one
// cycle per beat, then a single ACK cycle, so the requester samples the ack
// LATENCY+BEATSPERLINE+1 edges after the accept edge.
module cache_bus_responder
    import cache_bus_responder_pkg::*;
#(
    parameter int PA_BITS  = 32,
    parameter int LINELEN  = 256,
    parameter int BEATLEN  = 64,
    parameter int MEMLINES = 64,
    parameter int LATENCY  = 2
) (
    input  logic                        clk,
    input  logic                        reset_n,
    cache_bus_responder_if.slave        bus,
    output busRespState_t               StateDbg
);
    localparam int BEATSPERLINE = LINELEN / BEATLEN;
    localparam int LOGBWPL      = $clog2(BEATSPERLINE);
    localparam int OFFSETLEN    = $clog2(LINELEN / 8);
    localparam int LINEBITS     = $clog2(MEMLINES);
    localparam int LATW         = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    // WAIT exits when the counter reads zero, so it is loaded with LATENCY-1.
    localparam logic [LATW-1:0]    LATLOAD  = (LATENCY > 0) ? LATW'(LATENCY - 1) : '0;
    localparam logic [LOGBWPL-1:0] LASTBEAT = LOGBWPL'(BEATSPERLINE - 1);

    busRespState_t        state, stateNext;
    logic                 opIsWrite;
    logic [LINEBITS-1:0]  lineIdx;
    logic [LOGBWPL-1:0]   beatCnt;
    logic [LATW-1:0]      latCnt;
    logic [LINELEN-1:0]   fetchBuf;
    logic                 protoErr;
    logic                 illegalPrev;

    logic                 acceptReq, latDec, beatAdvance, beatClear, ramWe, fetchWe;
    logic                 reqRead, reqWrite, reqNone, illegalNow;
    logic [PA_BITS-1:0]   reqAdr;
    logic [BEATLEN-1:0]   ramRdata;
    logic                 unusedAdrBits;

    assign reqRead    = (bus.CacheBusRW == BUS_RW_READ);
    assign reqWrite   = (bus.CacheBusRW == BUS_RW_WRITE);
    assign reqNone    = (bus.CacheBusRW == BUS_RW_NONE);
    assign illegalNow = (state == ST_IDLE) && (bus.CacheBusRW == BUS_RW_ILLEGAL);
    assign reqAdr     = bus.CacheBusAdr;
    // Only the line index bits address the store; the rest are ignored.
    assign unusedAdrBits = ^{reqAdr[PA_BITS-1:OFFSETLEN+LINEBITS], reqAdr[OFFSETLEN-1:0]};

    busresp_ram #(
        .DEPTH (MEMLINES * BEATSPERLINE),
        .WIDTH (BEATLEN)
    ) u_ram (
        .clk   (clk),
        .we    (ramWe),
        .addr  ({lineIdx, beatCnt}),
        .wdata (bus.WriteBeatData),
        .rdata (ramRdata)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext   = state;
        acceptReq   = 1'b0;
        latDec      = 1'b0;
        beatAdvance = 1'b0;
        beatClear   = 1'b0;
        ramWe       = 1'b0;
        fetchWe     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (reqRead || reqWrite) begin
                    acceptReq = 1'b1;
                    if (LATENCY == 0) begin
                        stateNext = reqWrite ? ST_WRITE : ST_READ;
                    end else begin
                        stateNext = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (reqNone) begin
                    stateNext = ST_IDLE;
                end else if (latCnt == '0) begin
                    stateNext = opIsWrite ? ST_WRITE : ST_READ;
                end else begin
                    latDec = 1'b1;
                end
            end
            ST_READ, ST_WRITE: begin
                if (reqNone) begin
                    // Requester flush: drop the burst without touching this beat.
                    stateNext = ST_IDLE;
                    beatClear = 1'b1;
                end else begin
                    ramWe   = (state == ST_WRITE);
                    fetchWe = (state == ST_READ);
                    if (beatCnt == LASTBEAT) begin
                        beatClear = 1'b1;
                        stateNext = ST_ACK;
                    end else begin
                        beatAdvance = 1'b1;
                    end
                end
            end
            ST_ACK: begin
                stateNext = ST_IDLE;
            end
            default: begin
                stateNext = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            opIsWrite   <= 1'b0;
            lineIdx     <= '0;
            beatCnt     <= '0;
            latCnt      <= '0;
            fetchBuf    <= '0;
            protoErr    <= 1'b0;
            illegalPrev <= 1'b0;
        end else begin
            // Pulse once per illegal request even if the requester holds 11.
            illegalPrev <= illegalNow;
            protoErr    <= illegalNow && !illegalPrev;
            if (acceptReq) begin
                opIsWrite <= reqWrite;
                lineIdx   <= reqAdr[OFFSETLEN +: LINEBITS];
                latCnt    <= LATLOAD;
            end else if (latDec) begin
                latCnt <= latCnt - LATW'(1);
            end
            if (fetchWe) begin
                fetchBuf[int'(beatCnt)*BEATLEN +: BEATLEN] <= ramRdata;
            end
            if (beatClear) begin
                beatCnt <= '0;
            end else if (beatAdvance) begin
                beatCnt <= beatCnt + LOGBWPL'(1);
            end
        end
    end

    assign bus.FetchBuffer = fetchBuf;
    assign bus.BeatCount   = beatCnt;
    assign bus.SelBusBeat  = (state == ST_WRITE);
    assign bus.CacheBusAck = (state == ST_ACK);
    assign bus.ProtocolErr = protoErr;
    assign StateDbg        = state;
endmodule

// File: tb/tb_cache_bus_responder.sv
// Bench for cache_bus_responder: one instance with LATENCY=2 and one with
// LATENCY=0, a transaction table with per-cycle expected outputs, a queue of
// expected fetched lines, and hand sequences for error, abort and reset.
module tb_cache_bus_responder;
    import cache_bus_responder_pkg::*;

    localparam int LW  = 256;
    localparam int BW  = 64;
    localparam int BPL = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    cache_bus_responder_if #(.PA_BITS(32), .LINELEN(LW), .BEATLEN(BW)) bus0 ();
    cache_bus_responder_if #(.PA_BITS(32), .LINELEN(LW), .BEATLEN(BW)) bus1 ();
    busRespState_t st0, st1;

    cache_bus_responder #(.LATENCY(2)) dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0.slave), .StateDbg(st0));
    cache_bus_responder #(.LATENCY(0)) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1.slave), .StateDbg(st1));

    logic [1:0]    rw [2];
    logic [31:0]   adr [2];
    logic [LW-1:0] wline [2];
    logic          ack [2];
    logic          sel [2];
    logic          err [2];
    logic [1:0]    bc [2];
    logic [LW-1:0] fetch [2];
    busRespState_t st [2];

    assign bus0.CacheBusRW    = rw[0];
    assign bus0.CacheBusAdr   = adr[0];
    assign bus0.WriteBeatData = wline[0][int'(bus0.BeatCount)*BW +: BW];
    assign bus1.CacheBusRW    = rw[1];
    assign bus1.CacheBusAdr   = adr[1];
    assign bus1.WriteBeatData = wline[1][int'(bus1.BeatCount)*BW +: BW];
    assign ack[0] = bus0.CacheBusAck;  assign ack[1] = bus1.CacheBusAck;
    assign sel[0] = bus0.SelBusBeat;   assign sel[1] = bus1.SelBusBeat;
    assign err[0] = bus0.ProtocolErr;  assign err[1] = bus1.ProtocolErr;
    assign bc[0]  = bus0.BeatCount;    assign bc[1]  = bus1.BeatCount;
    assign fetch[0] = bus0.FetchBuffer; assign fetch[1] = bus1.FetchBuffer;
    assign st[0] = st0;                assign st[1] = st1;

    int lat [2] = '{2, 0};
    int n_cmp = 0;
    int n_fail = 0;
    logic [LW-1:0] exp_q [$];
    logic [LW-1:0] lastFetch [2];
    bit            haveLast [2];

    typedef struct {
        int            dut;
        logic [1:0]    op;
        int            line;
        logic [LW-1:0] data;
        logic [LW-1:0] expFetch;
        bit            wiggle;
    } vec_t;
    vec_t vecs [11];

    function automatic logic [LW-1:0] mkline(input logic [63:0] base);
        return {base + 64'd3, base + 64'd2, base + 64'd1, base};
    endfunction

    task automatic check(input string name, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Drives one request from IDLE and checks every cycle up to the ack.
    // Returns in the ack cycle with CacheBusRW already dropped.
    task automatic run_op(input int dut, input logic [1:0] op, input int line,
                          input logic [LW-1:0] data, input logic [LW-1:0] expFetch,
                          input bit wiggle);
        int L;
        int last_c;
        int b;
        logic [4:0] got;
        logic [4:0] exp;
        logic [LW-1:0] e;
        L = lat[dut];
        last_c = L + BPL + 1;
        @(negedge clk);
        check($sformatf("idle_d%0d_line%0d", dut, line), {ack[dut], st[dut]}, {1'b0, ST_IDLE});
        if (haveLast[dut]) check($sformatf("fetch_hold_d%0d", dut), fetch[dut], lastFetch[dut]);
        wline[dut] = data;
        adr[dut]   = 32'(line) << 5;
        rw[dut]    = op;
        if (op == BUS_RW_READ) exp_q.push_back(expFetch);
        for (int c = 1; c <= last_c; c++) begin
            @(negedge clk);
            b = c - L - 1;
            exp = {1'b0, (c == last_c), (op == BUS_RW_WRITE) && (b >= 0) && (b < BPL),
                   ((b >= 0) && (b < BPL)) ? 2'(b) : 2'd0};
            got = {err[dut], ack[dut], sel[dut], bc[dut]};
            check($sformatf("cycle_d%0d_line%0d_c%0d", dut, line, c), {251'd0, got}, {251'd0, exp});
            if (wiggle && b == 1) begin
                adr[dut] = adr[dut] ^ 32'h0000_01e0;
                rw[dut]  = (op == BUS_RW_READ) ? BUS_RW_WRITE : BUS_RW_READ;
            end
        end
        rw[dut] = BUS_RW_NONE;
        if (op == BUS_RW_READ) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL scoreboard_empty: got ack with no expected line queued");
            end else begin
                e = exp_q.pop_front();
                check($sformatf("fetch_d%0d_line%0d", dut, line), fetch[dut], e);
                lastFetch[dut] = e;
                haveLast[dut]  = 1'b1;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [LW-1:0] la, ld, lg, lh, lk, lf, le;
        logic          ackSeen;
        la = mkline(64'hA0A0_0000_0000_0000);
        ld = mkline(64'hD0D0_1111_0000_0000);
        lg = mkline(64'h6060_2222_0000_0000);
        lh = mkline(64'h4848_3333_0000_0000);
        lk = mkline(64'hCAFE_4444_0000_0000);
        lf = mkline(64'hF0F0_5555_0000_0000);
        le = mkline(64'hEEEE_6666_0000_0000);
        vecs[0]  = '{0, BUS_RW_WRITE, 5,  la, '0, 1'b0};
        vecs[1]  = '{0, BUS_RW_READ,  5,  '0, la, 1'b0};
        vecs[2]  = '{0, BUS_RW_WRITE, 9,  ld, '0, 1'b1};
        vecs[3]  = '{0, BUS_RW_READ,  9,  '0, ld, 1'b1};
        vecs[4]  = '{0, BUS_RW_WRITE, 7,  lg, '0, 1'b0};
        vecs[5]  = '{0, BUS_RW_WRITE, 3,  lh, '0, 1'b0};
        vecs[6]  = '{0, BUS_RW_READ,  7,  '0, lg, 1'b0};
        vecs[7]  = '{1, BUS_RW_WRITE, 2,  lk, '0, 1'b0};
        vecs[8]  = '{1, BUS_RW_READ,  2,  '0, lk, 1'b0};
        vecs[9]  = '{0, BUS_RW_WRITE, 12, lf, '0, 1'b0};
        vecs[10] = '{0, BUS_RW_READ,  3,  '0, lh, 1'b0};

        for (int d = 0; d < 2; d++) begin
            rw[d] = BUS_RW_NONE;
            adr[d] = '0;
            wline[d] = '0;
            lastFetch[d] = '0;
            haveLast[d] = 1'b1;
        end

        // Reset state while reset_n is held low.
        #2;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset_fetch_d%0d", d), fetch[d], '0);
            check($sformatf("reset_ctl_d%0d", d), {err[d], ack[d], sel[d], bc[d], st[d]}, {5'b0, ST_IDLE});
        end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Table: writebacks, fetches, back-to-back, mid-op changes, LATENCY=0.
        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].dut, vecs[i].op, vecs[i].line, vecs[i].data, vecs[i].expFetch, vecs[i].wiggle);
        end

        // Illegal request in IDLE.
        @(negedge clk);
        rw[0] = BUS_RW_ILLEGAL;
        @(negedge clk);
        check("proto_err_pulse", {err[0], ack[0], st[0]}, {2'b10, ST_IDLE});
        rw[0] = BUS_RW_NONE;
        @(negedge clk);
        check("proto_err_end", {err[0], ack[0], st[0]}, {2'b00, ST_IDLE});
        check("proto_err_fetch_hold", fetch[0], lh);

        // Requester flush at beat 1 of a read.
        @(negedge clk);
        adr[0] = 32'd5 << 5;
        rw[0]  = BUS_RW_READ;
        for (int c = 1; c <= lat[0] + 2; c++) @(negedge clk);
        check("abort_at_beat1", {30'd0, bc[0]}, 32'd1);
        rw[0] = BUS_RW_NONE;
        @(negedge clk);
        check("abort_idle", {ack[0], bc[0], st[0]}, {3'b000, ST_IDLE});
        ackSeen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            ackSeen = ackSeen | ack[0];
        end
        check("abort_no_ack", {255'd0, ackSeen}, '0);

        // Reset during beat 2 of a writeback over line 12 (holds lf).
        @(negedge clk);
        wline[0] = le;
        adr[0]   = 32'd12 << 5;
        rw[0]    = BUS_RW_WRITE;
        for (int c = 1; c <= lat[0] + 3; c++) @(negedge clk);
        check("pre_reset_beat2", {sel[0], bc[0]}, 3'b110);
        #1;
        reset_n = 1'b0;
        rw[0]   = BUS_RW_NONE;
        #1;
        check("async_reset_fetch", fetch[0], '0);
        check("async_reset_ctl", {err[0], ack[0], sel[0], bc[0], st[0]}, {5'b0, ST_IDLE});
        #1;
        reset_n = 1'b1;
        ackSeen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            ackSeen = ackSeen | ack[0];
        end
        check("reset_no_ack", {255'd0, ackSeen}, '0);
        lastFetch[0] = '0;
        haveLast[0]  = 1'b1;
        run_op(0, BUS_RW_READ, 12, '0, {lf[255:128], le[127:0]}, 1'b0);

        @(negedge clk);
        check("scoreboard_drained", 256'(exp_q.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
